// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - Read-side drain stage: FIFO read port to valid/ready stream
// Three-entry elastic buffer; read issue depends only on registered state, i_empty and rst.
module fifo_rd_stream #(
    parameter int P_DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_empty,
    output logic                o_r_en,
    input  logic [P_DATA_W-1:0] i_rd_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [P_DATA_W-1:0] o_data,
    output logic [1:0]          o_level
);
    logic [P_DATA_W-1:0] data_buf [3];
    logic [1:0]          wr_idx;
    logic [1:0]          rd_idx;
    logic [1:0]          count;
    logic                pend;
    logic                pop;
    logic [2:0]          in_flight;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // A read is only issued if the word it returns is guaranteed a free slot.
    assign in_flight = {1'b0, count} + {2'b00, pend};
    assign o_r_en    = !rst && !i_empty && (in_flight < 3'd3);
    assign o_valid   = (count != 2'd0);
    assign pop       = o_valid && i_ready;
    assign o_level   = count;

    always_comb begin
        case (rd_idx)
            2'd0:    o_data = data_buf[0];
            2'd1:    o_data = data_buf[1];
            default: o_data = data_buf[2];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                data_buf[i] <= '0;
            end
            wr_idx <= 2'd0;
            rd_idx <= 2'd0;
            count  <= 2'd0;
            pend   <= 1'b0;
        end else begin
            pend <= o_r_en;
            // Read data arrives one cycle after the enable; capture it unconditionally.
            if (pend) begin
                case (wr_idx)
                    2'd0:    data_buf[0] <= i_rd_data;
                    2'd1:    data_buf[1] <= i_rd_data;
                    default: data_buf[2] <= i_rd_data;
                endcase
                wr_idx <= next_idx(wr_idx);
            end
            if (pop) begin
                rd_idx <= next_idx(rd_idx);
            end
            count <= count + {1'b0, pend} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - Directed and randomised bench for fifo_rd_stream
// A queue models the FIFO contents; delivered words are collected for in-order comparison.
module tb_fifo_rd_stream;
    logic       clk;
    logic       rst;
    logic       i_empty;
    logic       o_r_en;
    logic [7:0] i_rd_data;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_data;
    logic [1:0] o_level;

    fifo_rd_stream #(.P_DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_empty   (i_empty),
        .o_r_en    (o_r_en),
        .i_rd_data (i_rd_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_level   (o_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         nvec = 0;
    int         nerr = 0;
    int         viol_empty = 0;
    int         viol_fill = 0;
    logic [7:0] fifo_q [$];
    logic [7:0] got_q [$];
    logic       last_r_en = 1'b0;
    logic       ob_r_en;
    logic       ob_valid;
    logic [7:0] ob_data;
    logic [1:0] ob_level;

    // One read-domain cycle: drive at the negedge, observe settled outputs before the next posedge.
    task automatic step(input logic r, input logic rdy, input logic fe);
        logic pend_now;
        @(negedge clk);
        pend_now = last_r_en;
        if (last_r_en) begin
            if (fifo_q.size() > 0) begin
                i_rd_data = fifo_q.pop_front();
            end else begin
                i_rd_data = 8'h00;
                viol_empty++;
            end
        end
        rst     = r;
        i_ready = rdy;
        i_empty = fe || (fifo_q.size() == 0);
        #1;
        ob_r_en  = o_r_en;
        ob_valid = o_valid;
        ob_data  = o_data;
        ob_level = o_level;
        if (o_r_en && i_empty) viol_empty++;
        if (!r && (int'(o_level) + int'(pend_now) > 3)) viol_fill++;
        if (!r && o_valid && rdy) got_q.push_back(o_data);
        last_r_en = o_r_en;
    endtask

    task automatic test_reset();
        fifo_q = {8'h11};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0);
            nvec++;
            if (ob_r_en !== 1'b0) begin
                nerr++;
                $display("FAIL reset_r_en cycle %0d: got %b expected 0", i, ob_r_en);
            end
        end
        nvec++;
        if (ob_valid !== 1'b0) begin
            nerr++;
            $display("FAIL reset_valid: got %b expected 0", ob_valid);
        end
        nvec++;
        if (ob_level !== 2'd0) begin
            nerr++;
            $display("FAIL reset_level: got %0d expected 0", ob_level);
        end
        nvec++;
        if (ob_data !== 8'h00) begin
            nerr++;
            $display("FAIL reset_data: got %h expected 00", ob_data);
        end
        fifo_q.delete();
        step(1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_single();
        logic       rv [5];
        logic       vv [5];
        logic [7:0] dv [5];
        got_q.delete();
        fifo_q = {8'hA5};
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0);
            rv[i] = ob_r_en;
            vv[i] = ob_valid;
            dv[i] = ob_data;
        end
        for (int i = 0; i < 5; i++) begin
            nvec++;
            if (rv[i] !== (i == 0)) begin
                nerr++;
                $display("FAIL single_r_en cycle %0d: got %b expected %b", i, rv[i], (i == 0));
            end
            nvec++;
            if (vv[i] !== (i == 2)) begin
                nerr++;
                $display("FAIL single_valid cycle %0d: got %b expected %b", i, vv[i], (i == 2));
            end
        end
        nvec++;
        if (dv[2] !== 8'hA5) begin
            nerr++;
            $display("FAIL single_data: got %h expected a5", dv[2]);
        end
    endtask

    task automatic test_streaming();
        logic       rv [14];
        logic       vv [14];
        logic [7:0] dv [14];
        logic [7:0] exp_d;
        got_q.delete();
        for (int i = 0; i < 10; i++) fifo_q.push_back(8'(i));
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 1'b1, 1'b0);
            rv[i] = ob_r_en;
            vv[i] = ob_valid;
            dv[i] = ob_data;
        end
        for (int i = 0; i < 14; i++) begin
            nvec++;
            if (rv[i] !== (i < 10)) begin
                nerr++;
                $display("FAIL stream_r_en cycle %0d: got %b expected %b", i, rv[i], (i < 10));
            end
            nvec++;
            if (vv[i] !== (i >= 2 && i < 12)) begin
                nerr++;
                $display("FAIL stream_valid cycle %0d: got %b expected %b", i, vv[i], (i >= 2 && i < 12));
            end
            if (i >= 2 && i < 12) begin
                exp_d = 8'(i - 2);
                nvec++;
                if (dv[i] !== exp_d) begin
                    nerr++;
                    $display("FAIL stream_data cycle %0d: got %h expected %h", i, dv[i], exp_d);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int         pulses = 0;
        int         max_level = 0;
        logic       held_ok = 1'b1;
        logic [7:0] exp_d;
        got_q.delete();
        for (int i = 0; i < 6; i++) fifo_q.push_back(8'h30 + 8'(i));
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (ob_r_en) pulses++;
            if (int'(ob_level) > max_level) max_level = int'(ob_level);
            if (ob_valid && ob_data !== 8'h30) held_ok = 1'b0;
        end
        nvec++;
        if (pulses !== 3) begin
            nerr++;
            $display("FAIL bp_pulses: got %0d expected 3", pulses);
        end
        nvec++;
        if (max_level !== 3) begin
            nerr++;
            $display("FAIL bp_level_max: got %0d expected 3", max_level);
        end
        nvec++;
        if (held_ok !== 1'b1) begin
            nerr++;
            $display("FAIL bp_data_held: got %b expected 1", held_ok);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (ob_r_en) pulses++;
        end
        nvec++;
        if (pulses !== 6) begin
            nerr++;
            $display("FAIL bp_total_reads: got %0d expected 6", pulses);
        end
        nvec++;
        if (got_q.size() !== 6) begin
            nerr++;
            $display("FAIL bp_count: got %0d expected 6", got_q.size());
        end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            exp_d = 8'h30 + 8'(i);
            nvec++;
            if (got_q[i] !== exp_d) begin
                nerr++;
                $display("FAIL bp_order word %0d: got %h expected %h", i, got_q[i], exp_d);
            end
        end
        nvec++;
        if (ob_level !== 2'd0) begin
            nerr++;
            $display("FAIL bp_level_end: got %0d expected 0", ob_level);
        end
    endtask

    task automatic test_random();
        int         budget = 0;
        int         bad = 0;
        logic [7:0] exp_d;
        got_q.delete();
        viol_empty = 0;
        viol_fill = 0;
        for (int i = 0; i < 200; i++) fifo_q.push_back(8'(i) ^ 8'h5A);
        while (got_q.size() < 200 && budget < 3000) begin
            step(1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            budget++;
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
        nvec++;
        if (got_q.size() !== 200) begin
            nerr++;
            $display("FAIL rand_count: got %0d expected 200 (cycles %0d)", got_q.size(), budget);
        end
        for (int i = 0; i < 200 && i < got_q.size(); i++) begin
            exp_d = 8'(i) ^ 8'h5A;
            if (got_q[i] !== exp_d) bad++;
        end
        nvec++;
        if (bad !== 0) begin
            nerr++;
            $display("FAIL rand_order: got %0d wrong words expected 0", bad);
        end
        nvec++;
        if (viol_empty !== 0) begin
            nerr++;
            $display("FAIL rand_read_on_empty: got %0d expected 0", viol_empty);
        end
        nvec++;
        if (viol_fill !== 0) begin
            nerr++;
            $display("FAIL rand_overfill: got %0d expected 0", viol_fill);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_d;
        got_q.delete();
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'hC0 + 8'(i));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        nvec++;
        if (ob_level !== 2'd2) begin
            nerr++;
            $display("FAIL rmid_level_at_reset: got %0d expected 2", ob_level);
        end
        step(1'b0, 1'b1, 1'b0);
        nvec++;
        if (ob_valid !== 1'b0) begin
            nerr++;
            $display("FAIL rmid_valid_after: got %b expected 0", ob_valid);
        end
        nvec++;
        if (ob_level !== 2'd0) begin
            nerr++;
            $display("FAIL rmid_level_after: got %0d expected 0", ob_level);
        end
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0);
        nvec++;
        if (got_q.size() !== 5) begin
            nerr++;
            $display("FAIL rmid_count: got %0d expected 5", got_q.size());
        end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            exp_d = 8'hC3 + 8'(i);
            nvec++;
            if (got_q[i] !== exp_d) begin
                nerr++;
                $display("FAIL rmid_order word %0d: got %h expected %h", i, got_q[i], exp_d);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        i_empty   = 1'b1;
        i_ready   = 1'b0;
        i_rd_data = 8'h00;
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
